// File: rtl/hz_square_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hz_square_pkg
// Description : Shared constants for the multi-channel square-wave test
//               generator: counter/amplitude widths, reset waveform (13 Hz at
//               50 MHz) and the config channel-select width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package hz_square_pkg;

    localparam int          HZ_CLK_RATE   = 50000000;
    localparam int          HZ_CNT_W      = 26;
    localparam int          HZ_AMP_W      = 12;
    localparam int unsigned HZ_DEF_PERIOD = 3846153;
    localparam int unsigned HZ_DEF_HIGH   = 1923076;

    // Width of a channel-select field; never narrower than one bit.
    function automatic int hz_ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : hz_square_pkg
`default_nettype wire

// File: rtl/hz_square_chan.sv
`default_nettype none
// ============================================================================
// Module      : hz_square_chan
// Description : One square-wave generator channel. Holds the period counter,
//               active and shadow period/high registers with a pending flag,
//               and the registered pulse / edge / wrap / level outputs.
//               New settings only take effect at a period wrap (or at once
//               when the channel is disabled), so the waveform never glitches.
// Revision    : 1.0 - initial release
// ============================================================================
module hz_square_chan
    import hz_square_pkg::*;
#(
    parameter int          CNT_W      = HZ_CNT_W,
    parameter int          AMP_W      = HZ_AMP_W,
    parameter int unsigned DEF_PERIOD = HZ_DEF_PERIOD,
    parameter int unsigned DEF_HIGH   = HZ_DEF_HIGH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pause,
    input  logic             wr_en,
    input  logic [CNT_W-1:0] wr_period,
    input  logic [CNT_W-1:0] wr_high,
    output logic             pending,
    output logic             pulse,
    output logic             edge_strobe,
    output logic             wrap,
    output logic [AMP_W-1:0] level
);

    localparam logic [CNT_W-1:0] C_DEF_PERIOD = CNT_W'(DEF_PERIOD);
    localparam logic [CNT_W-1:0] C_DEF_HIGH   = CNT_W'(DEF_HIGH);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_high;
    logic [CNT_W-1:0] r_sh_period;
    logic [CNT_W-1:0] r_sh_high;
    logic             r_pending;
    logic             r_pulse;
    logic             r_edge;
    logic             r_wrap;

    logic             w_enabled;
    logic [CNT_W-1:0] w_last;
    logic             w_at_end;
    logic             w_pulse_nxt;
    logic             w_load;
    logic             w_accept;

    // A period below 2 cannot toggle, so it is treated as "channel off".
    assign w_enabled   = (r_period >= CNT_W'(2));
    assign w_last      = r_period - CNT_W'(1);
    assign w_at_end    = w_enabled && (r_cnt == w_last);
    assign w_pulse_nxt = w_enabled && (r_cnt < r_high);
    // Shadow settings land on a wrap, or on any active cycle of an off channel.
    assign w_load      = !pause && r_pending && (w_at_end || !w_enabled);
    // Only one outstanding write per channel; the top already gates this.
    assign w_accept    = wr_en && !r_pending;

    // Period counter plus active/shadow settings and the pending handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_period    <= C_DEF_PERIOD;
            r_high      <= C_DEF_HIGH;
            r_sh_period <= C_DEF_PERIOD;
            r_sh_high   <= C_DEF_HIGH;
            r_pending   <= 1'b0;
        end else begin
            if (!pause) begin
                if (!w_enabled || w_at_end) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
            if (w_load) begin
                r_period <= r_sh_period;
                r_high   <= r_sh_high;
            end
            // Accept and load are exclusive: accept needs pending low, load high.
            if (w_accept) begin
                r_sh_period <= wr_period;
                r_sh_high   <= wr_high;
                r_pending   <= 1'b1;
            end else if (w_load) begin
                r_pending   <= 1'b0;
            end
        end
    end

    // Registered waveform outputs; pause freezes pulse and silences strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pulse <= 1'b0;
            r_edge  <= 1'b0;
            r_wrap  <= 1'b0;
        end else if (pause) begin
            r_edge  <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            r_pulse <= w_pulse_nxt;
            r_edge  <= w_pulse_nxt ^ r_pulse;
            r_wrap  <= w_at_end;
        end
    end

    assign pending     = r_pending;
    assign pulse       = r_pulse;
    assign edge_strobe = r_edge;
    assign wrap        = r_wrap;
    assign level       = {AMP_W{r_pulse}};

endmodule : hz_square_chan
`default_nettype wire

// File: rtl/hz_square_multi.sv
`default_nettype none
// ============================================================================
// Module      : hz_square_multi
// Description : Multi-channel programmable square-wave test-signal generator.
//               Decodes config writes to per-channel generators and muxes the
//               selected channel's pending flag onto cfg_ready. Writes to a
//               channel index past the last channel are accepted and dropped.
//               "edge" is a reserved word, so the transition strobe port is
//               named edge_strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module hz_square_multi
    import hz_square_pkg::*;
#(
    parameter int          CHANNELS   = 2,
    parameter int          CNT_W      = HZ_CNT_W,
    parameter int          AMP_W      = HZ_AMP_W,
    parameter int unsigned DEF_PERIOD = HZ_DEF_PERIOD,
    parameter int unsigned DEF_HIGH   = HZ_DEF_HIGH
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         pause,
    input  logic                                         cfg_valid,
    output logic                                         cfg_ready,
    input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] cfg_ch,
    input  logic [CNT_W-1:0]                             cfg_period,
    input  logic [CNT_W-1:0]                             cfg_high,
    output logic [CHANNELS-1:0]                          pulse,
    output logic [CHANNELS*AMP_W-1:0]                    level,
    output logic [CHANNELS-1:0]                          edge_strobe,
    output logic [CHANNELS-1:0]                          wrap
);

    localparam int CH_W = hz_ch_width(CHANNELS);

    logic [CHANNELS-1:0] w_pending;
    logic [CHANNELS-1:0] w_wr;
    logic                w_ready;

    // Config decode: ready follows the addressed channel's pending flag.
    always_comb begin
        w_ready = 1'b1;
        w_wr    = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                w_ready = ~w_pending[i];
                w_wr[i] = cfg_valid & ~w_pending[i];
            end
        end
    end

    assign cfg_ready = w_ready;

    generate
        for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
            hz_square_chan #(
                .CNT_W      (CNT_W),
                .AMP_W      (AMP_W),
                .DEF_PERIOD (DEF_PERIOD),
                .DEF_HIGH   (DEF_HIGH)
            ) u_chan (
                .clk         (clk),
                .rst         (rst),
                .pause       (pause),
                .wr_en       (w_wr[g]),
                .wr_period   (cfg_period),
                .wr_high     (cfg_high),
                .pending     (w_pending[g]),
                .pulse       (pulse[g]),
                .edge_strobe (edge_strobe[g]),
                .wrap        (wrap[g]),
                .level       (level[g*AMP_W +: AMP_W])
            );
        end
    endgenerate

endmodule : hz_square_multi
`default_nettype wire

// File: tb/tb_hz_square_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_hz_square_multi
// Description : Scoreboard testbench for hz_square_multi. A driver applies
//               directed and random config/pause/reset stimulus, advances a
//               reference model built on "active cycles since last load" and
//               queues the expected outputs; a negedge monitor pops and
//               compares. Reset waveform is shortened to 37/18 cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hz_square_multi;

    localparam int CH    = 3;
    localparam int CH_W  = 2;
    localparam int CNT_W = 26;
    localparam int AMP_W = 12;
    localparam int DEFP  = 37;
    localparam int DEFH  = 18;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  pause = 1'b0;
    logic                  cfg_valid = 1'b0;
    logic                  cfg_ready;
    logic [CH_W-1:0]       cfg_ch = '0;
    logic [CNT_W-1:0]      cfg_period = '0;
    logic [CNT_W-1:0]      cfg_high = '0;
    logic [CH-1:0]         pulse;
    logic [CH*AMP_W-1:0]   level;
    logic [CH-1:0]         edge_strobe;
    logic [CH-1:0]         wrap;

    hz_square_multi #(
        .CHANNELS   (CH),
        .CNT_W      (CNT_W),
        .AMP_W      (AMP_W),
        .DEF_PERIOD (DEFP),
        .DEF_HIGH   (DEFH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pause       (pause),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_ch      (cfg_ch),
        .cfg_period  (cfg_period),
        .cfg_high    (cfg_high),
        .pulse       (pulse),
        .level       (level),
        .edge_strobe (edge_strobe),
        .wrap        (wrap)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic                ready;
        logic [CH-1:0]       pulse;
        logic [CH-1:0]       edg;
        logic [CH-1:0]       wrp;
        logic [CH*AMP_W-1:0] level;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: waveform phase = (active cycles since last load) mod P.
    int unsigned m_per[CH], m_hi[CH], m_sp[CH], m_sh[CH], m_el[CH];
    bit          m_pend[CH], m_pulse[CH], m_edge[CH], m_wrap[CH];

    function automatic void mdl_reset();
        for (int c = 0; c < CH; c++) begin
            m_per[c] = DEFP;  m_hi[c] = DEFH;
            m_sp[c]  = DEFP;  m_sh[c] = DEFH;
            m_el[c]  = 0;     m_pend[c] = 0;
            m_pulse[c] = 0;   m_edge[c] = 0;  m_wrap[c] = 0;
        end
    endfunction

    function automatic bit mdl_ready(input int ch);
        return (ch >= CH) ? 1'b1 : !m_pend[ch];
    endfunction

    function automatic void mdl_step(input bit p, input bit v, input int ch,
                                     input int unsigned per, input int unsigned hi);
        bit acc[CH];
        bit np, nw;
        int unsigned ph;
        for (int c = 0; c < CH; c++) acc[c] = v && (ch == c) && !m_pend[c];
        for (int c = 0; c < CH; c++) begin
            if (p) begin
                m_edge[c] = 0;
                m_wrap[c] = 0;
            end else begin
                if (m_per[c] < 2) begin
                    np = 0; nw = 0; m_el[c] = 0;
                    if (m_pend[c]) begin
                        m_per[c] = m_sp[c]; m_hi[c] = m_sh[c]; m_pend[c] = 0;
                    end
                end else begin
                    ph = m_el[c] % m_per[c];
                    np = (ph < m_hi[c]);
                    nw = (ph == m_per[c] - 1);
                    m_el[c]++;
                    if (nw && m_pend[c]) begin
                        m_per[c] = m_sp[c]; m_hi[c] = m_sh[c]; m_pend[c] = 0;
                        m_el[c] = 0;
                    end
                end
                m_edge[c]  = (np != m_pulse[c]);
                m_pulse[c] = np;
                m_wrap[c]  = nw;
            end
            if (acc[c]) begin
                m_sp[c] = per; m_sh[c] = hi; m_pend[c] = 1;
            end
        end
    endfunction

    function automatic void push_exp();
        exp_t e;
        e.ready = mdl_ready(int'(cfg_ch));
        for (int c = 0; c < CH; c++) begin
            e.pulse[c] = m_pulse[c];
            e.edg[c]   = m_edge[c];
            e.wrp[c]   = m_wrap[c];
            e.level[c*AMP_W +: AMP_W] = m_pulse[c] ? AMP_W'((1 << AMP_W) - 1) : AMP_W'(0);
        end
        q.push_back(e);
    endfunction

    task automatic drive(input bit p, input bit v, input int ch,
                         input int unsigned per, input int unsigned hi);
        @(posedge clk); #1;
        pause      = p;
        cfg_valid  = v;
        cfg_ch     = CH_W'(ch);
        cfg_period = CNT_W'(per);
        cfg_high   = CNT_W'(hi);
        push_exp();
        mdl_step(p, v, ch, per, hi);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, 0, 0, 0);
    endtask

    task automatic write(input int ch, input int unsigned per, input int unsigned hi);
        drive(0, 1, ch, per, hi);
    endtask

    // Asynchronous reset asserted and released between clock edges.
    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; pause = 1'b0; cfg_valid = 1'b0;
        mdl_reset();
        push_exp();
        repeat (2) begin
            @(posedge clk); #1;
            push_exp();
        end
        rst = 1'b0;
        mdl_step(0, 0, 0, 0, 0);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: outputs are presented every cycle, compare on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("cfg_ready", 64'(cfg_ready),   64'(e.ready));
            chk("pulse",     64'(pulse),       64'(e.pulse));
            chk("level",     64'(level),       64'(e.level));
            chk("edge",      64'(edge_strobe), 64'(e.edg));
            chk("wrap",      64'(wrap),        64'(e.wrp));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int          pause_left;
        bit          rp, rv;
        int          rch;
        int unsigned rper, rhi;

        mdl_reset();
        do_reset();
        // Default waveform, no config.
        idle(100);

        // ch1 -> 10/3, a second write while pending is refused.
        write(1, 10, 3);
        write(1, 7, 7);
        idle(80);
        // Constant high: H >= P.
        write(1, 4, 4);
        idle(30);

        // Out-of-range channel index: always ready, no effect.
        repeat (3) drive(0, 1, 3, 5, 2);

        // Pause ch0 mid-high on a 10/5 waveform.
        write(0, 10, 5);
        for (int k = 0; k < 200 && !(m_per[0] == 10 && (m_el[0] % 10) == 2); k++) idle(1);
        repeat (20) drive(1, 0, 0, 0, 0);
        drive(1, 1, 2, 9, 4);
        repeat (5) drive(1, 0, 0, 0, 0);
        idle(40);

        // ch2 disabled, then re-enabled immediately.
        write(2, 1, 0);
        idle(60);
        write(2, 6, 2);
        idle(30);

        // Reset with a write pending on ch0.
        write(0, 5, 1);
        idle(2);
        do_reset();
        idle(100);

        // Randomized config, pause bursts and occasional resets.
        pause_left = 0;
        for (int k = 0; k < 3000; k++) begin
            if (pause_left > 0) begin
                rp = 1; pause_left--;
            end else begin
                rp = 0;
                if ($urandom_range(0, 39) == 0) pause_left = $urandom_range(1, 15);
            end
            rv   = ($urandom_range(0, 5) == 0);
            rch  = $urandom_range(0, 3);
            rper = $urandom_range(0, 13);
            rhi  = $urandom_range(0, 15);
            if ($urandom_range(0, 999) == 0) do_reset();
            else drive(rp, rv, rch, rper, rhi);
        end

        @(posedge clk); #1;
        pause = 1'b0; cfg_valid = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d queued expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_hz_square_multi
`default_nettype wire
